// File: rtl/scan_pkg.sv
// Shared types and constants for the scan sequencer slice.
package scan_pkg;

    localparam int NUM_CH      = 8;
    localparam int SEL_W       = 3;
    localparam int DEF_DWELL_W = 16;
    localparam int DEF_BLANK_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        BLANK  = 2'd2
    } state_t;

endpackage

// File: rtl/scan_sequencer_if.sv
// Control inputs and decoder-side outputs of the scan sequencer.
interface scan_sequencer_if
    import scan_pkg::*;
#(
    parameter int DWELL_W = DEF_DWELL_W,
    parameter int BLANK_W = DEF_BLANK_W
) ();

    logic               en;
    logic [NUM_CH-1:0]  mask;
    logic [DWELL_W-1:0] dwell;
    logic [BLANK_W-1:0] blank;
    logic [SEL_W-1:0]   sel;
    logic               sel_valid;
    logic               wrap;
    logic               busy;

    modport master (
        output en, mask, dwell, blank,
        input  sel, sel_valid, wrap, busy
    );

    modport slave (
        input  en, mask, dwell, blank,
        output sel, sel_valid, wrap, busy
    );

endinterface

// File: rtl/mask_next_sel.sv
// Finds the first enabled channel strictly above cur_sel, searching upward modulo NUM_CH.
// With cur_sel = NUM_CH-1 the result is the lowest enabled channel.
module mask_next_sel
    import scan_pkg::*;
(
    input  logic [NUM_CH-1:0] mask,
    input  logic [SEL_W-1:0]  cur_sel,
    output logic [SEL_W-1:0]  next_sel,
    output logic              wraps,
    output logic              none
);

    logic [SEL_W-1:0] idx_s;

    // Walk candidates from farthest to nearest so the nearest enabled one wins.
    always_comb begin
        next_sel = cur_sel;
        idx_s    = cur_sel;
        for (int i = NUM_CH; i >= 1; i--) begin
            idx_s    = cur_sel + SEL_W'(i);
            next_sel = mask[idx_s] ? idx_s : next_sel;
        end
    end

    assign none  = (mask == {NUM_CH{1'b0}});
    assign wraps = !none && (next_sel <= cur_sel);

endmodule

// File: rtl/scan_sequencer.sv
// Channel scan sequencer: walks enabled channels with a per-channel dwell
// and optional blanking gap, driving a registered 3-to-8 decoder select.
module scan_sequencer
    import scan_pkg::*;
#(
    parameter int DWELL_W = DEF_DWELL_W,
    parameter int BLANK_W = DEF_BLANK_W
) (
    input  logic              clk,
    input  logic              rst_n,
    scan_sequencer_if.slave   bus
);

    state_t             state_r, state_n;
    logic [SEL_W-1:0]   sel_r, sel_n;
    logic               sel_valid_r, sel_valid_n;
    logic               wrap_r, wrap_n;
    logic               busy_r, busy_n;
    logic [DWELL_W-1:0] dwell_cnt_r, dwell_n;
    logic [BLANK_W-1:0] blank_cnt_r, blank_n;

    logic               load_s, load_wrap_s;
    logic [SEL_W-1:0]   cur_sel_s, nxt_sel_s;
    logic               nxt_wraps_s, nxt_none_s;

    // From IDLE the search starts above the top channel, yielding the lowest set bit.
    assign cur_sel_s = (state_r == IDLE) ? SEL_W'(NUM_CH - 1) : sel_r;

    mask_next_sel u_next (
        .mask     (bus.mask),
        .cur_sel  (cur_sel_s),
        .next_sel (nxt_sel_s),
        .wraps    (nxt_wraps_s),
        .none     (nxt_none_s)
    );

    // Next-state and next-output logic.
    always_comb begin
        state_n     = state_r;
        sel_n       = sel_r;
        sel_valid_n = sel_valid_r;
        wrap_n      = 1'b0;
        busy_n      = busy_r;
        dwell_n     = dwell_cnt_r;
        blank_n     = blank_cnt_r;
        load_s      = 1'b0;
        load_wrap_s = 1'b0;
        if (!bus.en) begin
            state_n     = IDLE;
            sel_valid_n = 1'b0;
            busy_n      = 1'b0;
            dwell_n     = {DWELL_W{1'b0}};
            blank_n     = {BLANK_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (!nxt_none_s) begin
                        load_s = 1'b1;
                    end else begin
                        sel_valid_n = 1'b0;
                        busy_n      = 1'b0;
                    end
                end
                ACTIVE: begin
                    if (dwell_cnt_r > DWELL_W'(1)) begin
                        dwell_n = dwell_cnt_r - DWELL_W'(1);
                    end else if (blank_cnt_r != {BLANK_W{1'b0}}) begin
                        state_n     = BLANK;
                        sel_valid_n = 1'b0;
                    end else if (nxt_none_s) begin
                        state_n     = IDLE;
                        sel_valid_n = 1'b0;
                        busy_n      = 1'b0;
                        dwell_n     = {DWELL_W{1'b0}};
                    end else begin
                        load_s      = 1'b1;
                        load_wrap_s = nxt_wraps_s;
                    end
                end
                BLANK: begin
                    if (blank_cnt_r > BLANK_W'(1)) begin
                        blank_n = blank_cnt_r - BLANK_W'(1);
                    end else if (nxt_none_s) begin
                        state_n     = IDLE;
                        sel_valid_n = 1'b0;
                        busy_n      = 1'b0;
                        dwell_n     = {DWELL_W{1'b0}};
                        blank_n     = {BLANK_W{1'b0}};
                    end else begin
                        load_s      = 1'b1;
                        load_wrap_s = nxt_wraps_s;
                    end
                end
                default: begin
                    state_n     = IDLE;
                    sel_valid_n = 1'b0;
                    busy_n      = 1'b0;
                end
            endcase
            // dwell and blank are captured only when a channel's ACTIVE period starts.
            if (load_s) begin
                state_n     = ACTIVE;
                sel_n       = nxt_sel_s;
                sel_valid_n = 1'b1;
                busy_n      = 1'b1;
                wrap_n      = load_wrap_s;
                dwell_n     = (bus.dwell == {DWELL_W{1'b0}}) ? DWELL_W'(1) : bus.dwell;
                blank_n     = bus.blank;
            end else begin
                wrap_n      = 1'b0;
            end
        end
    end

    // State, counter and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            sel_r       <= {SEL_W{1'b0}};
            sel_valid_r <= 1'b0;
            wrap_r      <= 1'b0;
            busy_r      <= 1'b0;
            dwell_cnt_r <= {DWELL_W{1'b0}};
            blank_cnt_r <= {BLANK_W{1'b0}};
        end else begin
            state_r     <= state_n;
            sel_r       <= sel_n;
            sel_valid_r <= sel_valid_n;
            wrap_r      <= wrap_n;
            busy_r      <= busy_n;
            dwell_cnt_r <= dwell_n;
            blank_cnt_r <= blank_n;
        end
    end

    assign bus.sel       = sel_r;
    assign bus.sel_valid = sel_valid_r;
    assign bus.wrap      = wrap_r;
    assign bus.busy      = busy_r;

endmodule
